// File: rtl/pcs_loopback_err_inject.sv
// SERDES-side loopback: a fixed-latency block/header delay line with a run-based
// sync-header corruption engine for exercising the PCS RX block-lock logic.
module pcs_loopback_err_inject #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2,
  parameter int DELAY      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_hdr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [HDR_WIDTH-1:0]  out_hdr,
  input  logic                  cfg_start,
  input  logic [15:0]           cfg_offset,
  input  logic [7:0]            cfg_period,
  input  logic [7:0]            cfg_count,
  input  logic                  cfg_hdr_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  inject_active,
  output logic [15:0]           inject_count
);

  typedef enum logic [2:0] {IDLE, OFFSET, INJECT, GAP, DONE} state_t;

  localparam logic [HDR_WIDTH-1:0] HDR_RST = HDR_WIDTH'(2'b10);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] pipe_data [DELAY];
  logic [HDR_WIDTH-1:0]  pipe_hdr  [DELAY];
  logic [15:0]           timer, timer_nxt;
  logic [7:0]            remain, remain_nxt;
  logic [7:0]            period_q;
  logic                  mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) begin
        pipe_data[i] <= '0;
        pipe_hdr[i]  <= HDR_RST;
      end
    end else begin
      pipe_data[0] <= in_data;
      pipe_hdr[0]  <= in_hdr;
      for (int i = 1; i < DELAY; i++) begin
        pipe_data[i] <= pipe_data[i-1];
        pipe_hdr[i]  <= pipe_hdr[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      remain       <= '0;
      period_q     <= '0;
      mode_q       <= 1'b0;
      inject_count <= '0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      remain <= remain_nxt;
      // Run parameters are captured once so mid-run cfg_* changes are harmless.
      if (state == IDLE && cfg_start) begin
        period_q <= cfg_period;
        mode_q   <= cfg_hdr_mode;
      end
      if (state == INJECT && inject_count != 16'hFFFF)
        inject_count <= inject_count + 16'd1;
    end
  end

  // timer counts down the OFFSET/GAP dwell; leaving at 1 gives exactly N cycles.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    remain_nxt = remain;
    case (state)
      IDLE: if (cfg_start) begin
        remain_nxt = cfg_count;
        timer_nxt  = cfg_offset;
        if (cfg_count == 8'd0)        state_nxt = DONE;
        else if (cfg_offset != 16'd0) state_nxt = OFFSET;
        else                          state_nxt = INJECT;
      end
      OFFSET, GAP: begin
        if (timer == 16'd1) state_nxt = INJECT;
        else                timer_nxt = timer - 16'd1;
      end
      INJECT: begin
        remain_nxt = remain - 8'd1;
        if (remain == 8'd1) state_nxt = DONE;
        else if (period_q != 8'd0) begin
          state_nxt = GAP;
          timer_nxt = {8'd0, period_q};
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy          = !rst && (state == OFFSET || state == INJECT || state == GAP);
  assign done          = !rst && (state == DONE);
  assign inject_active = !rst && (state == INJECT);
  assign out_data      = pipe_data[DELAY-1];
  assign out_hdr       = inject_active ? (mode_q ? '1 : '0) : pipe_hdr[DELAY-1];

endmodule
